// File: rtl/fir_stim_sequencer.sv
// Input-side sequencer for the 3-tap Q2.6 FIR_Filter: loads coefficients serially, streams a
// stored sample block, flushes with zeros and captures one filter result per streamed sample.
module fir_stim_sequencer #(
  parameter int WL    = 8,
  parameter int NTAPS = 3,
  parameter int NSAMP = 4,
  parameter int AW    = 3,
  parameter int Y_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [WL-1:0] cfg_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [WL-1:0] x,
  output logic [WL-1:0] h,
  output logic          x_en,
  input  logic [WL-1:0] y_in,
  output logic [WL-1:0] y_out,
  output logic          y_valid
);

  localparam int DEPTH   = 1 << AW;
  localparam int CNT_MAX = (NTAPS > NSAMP) ? ((NTAPS > Y_LAT + 1) ? NTAPS : Y_LAT + 1)
                                           : ((NSAMP > Y_LAT + 1) ? NSAMP : Y_LAT + 1);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STREAM, ST_FLUSH, ST_DRAIN} state_t;

  localparam cnt_t LOAD_END   = cnt_t'(NTAPS - 1);
  localparam cnt_t STREAM_END = cnt_t'(NSAMP - 1);
  localparam cnt_t FLUSH_END  = cnt_t'(NTAPS - 2);
  // DRAIN lasts one cycle beyond Y_LAT so done appears while busy is still high.
  localparam cnt_t DRAIN_END  = cnt_t'(Y_LAT);

  state_t state, state_d;
  cnt_t   cnt, cnt_d;

  logic [WL-1:0] coef [DEPTH];
  logic [WL-1:0] samp [DEPTH];

  logic          wr_coef, wr_samp;
  logic [AW-1:0] coef_a, samp_a;
  logic [WL-1:0] x_d, h_d;
  logic          x_en_d, live_d, last_d;
  logic          live, last;
  logic [Y_LAT-1:0] v_pipe, t_pipe;

  assign wr_coef = cfg_we && !busy && !cfg_sel && (int'(cfg_addr) < NTAPS);
  assign wr_samp = cfg_we && !busy &&  cfg_sel && (int'(cfg_addr) < NSAMP);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state;
    cnt_d   = cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD:
        if (cnt == LOAD_END) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      ST_STREAM:
        if (cnt == STREAM_END) begin
          state_d = (NTAPS > 1) ? ST_FLUSH : ST_DRAIN;
          cnt_d   = '0;
        end
      ST_FLUSH:
        if (cnt == FLUSH_END) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      ST_DRAIN:
        if (cnt == DRAIN_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it. A table write
  // landing in the same edge is forwarded, so write+start uses the new value.
  always_comb begin
    x_en_d = 1'b0;
    h_d    = '0;
    x_d    = '0;
    live_d = 1'b0;
    last_d = 1'b0;
    coef_a = AW'(NTAPS - 1) - AW'(cnt_d);
    samp_a = AW'(cnt_d);
    case (state_d)
      ST_LOAD: begin
        x_en_d = 1'b1;
        h_d    = (wr_coef && cfg_addr == coef_a) ? cfg_data : coef[coef_a];
      end
      ST_STREAM: begin
        live_d = 1'b1;
        x_d    = (wr_samp && cfg_addr == samp_a) ? cfg_data : samp[samp_a];
        last_d = (NTAPS == 1) && (cnt_d == STREAM_END);
      end
      ST_FLUSH: begin
        live_d = 1'b1;
        last_d = (cnt_d == FLUSH_END);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      x_en  <= 1'b0;
      x     <= '0;
      h     <= '0;
      live  <= 1'b0;
      last  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_d;
      cnt   <= cnt_d;
      busy  <= (state_d != ST_IDLE);
      x_en  <= x_en_d;
      x     <= x_d;
      h     <= h_d;
      live  <= live_d;
      last  <= last_d;
    end
  end

  // NOTE: the tables are cleared by reset because a pass after reset must see all-zero data;
  // this keeps them in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        coef[i] <= '0;
        samp[i] <= '0;
      end
    end else begin
      if (wr_coef) coef[cfg_addr] <= cfg_data;
      if (wr_samp) samp[cfg_addr] <= cfg_data;
    end
  end

  // Valid/tag pipeline matches the filter latency; the tag marks the final result of the pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_pipe  <= '0;
      t_pipe  <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      v_pipe[0] <= live;
      t_pipe[0] <= last;
      for (int k = 1; k < Y_LAT; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        t_pipe[k] <= t_pipe[k-1];
      end
      y_valid <= v_pipe[Y_LAT-1];
      done    <= t_pipe[Y_LAT-1];
      if (v_pipe[Y_LAT-1]) y_out <= y_in;
    end
  end

endmodule

// File: tb/tb_fir_stim_sequencer.sv
// Scoreboard bench for fir_stim_sequencer: a pass-level model queues the expected drive
// sequence and result slots whenever a start is accepted; monitors pop and compare.
module tb_fir_stim_sequencer;

  localparam int WL    = 8;
  localparam int NTAPS = 3;
  localparam int NSAMP = 4;
  localparam int AW    = 3;
  localparam int Y_LAT = 1;
  localparam int PASS_LEN = NTAPS + NSAMP + NTAPS - 1 + Y_LAT + 1;
  localparam int NOUT     = NSAMP + NTAPS - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WL-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          busy, done, x_en, y_valid;
  logic [WL-1:0] x, h, y_out;
  logic [WL-1:0] y_in = '0;

  fir_stim_sequencer #(.WL(WL), .NTAPS(NTAPS), .NSAMP(NSAMP), .AW(AW), .Y_LAT(Y_LAT)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .busy(busy), .done(done), .x(x), .h(h), .x_en(x_en),
    .y_in(y_in), .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic x_en; logic [WL-1:0] h; logic [WL-1:0] x; } drv_t;
  typedef struct { int cyc; logic done; } yexp_t;

  drv_t  drv_q[$];
  yexp_t y_q[$];
  logic [WL-1:0] coef_m [8];
  logic [WL-1:0] samp_m [8];
  logic [WL-1:0] yhist [16384];
  int busy_end = -1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle n spans posedge n to posedge n+1; y_in is randomised each cycle and recorded.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    y_in = WL'($urandom);
    yhist[cyc % 16384] = y_in;
  end

  // Reference model: a pass is a fixed list of drive cycles and result slots built from the tables.
  always @(negedge clk) begin
    int n;
    if (!reset) begin
      if (cfg_we && cyc > busy_end) begin
        if (!cfg_sel && int'(cfg_addr) < NTAPS) coef_m[cfg_addr] = cfg_data;
        if (cfg_sel && int'(cfg_addr) < NSAMP)  samp_m[cfg_addr] = cfg_data;
      end
      if (start && cyc > busy_end) begin
        n = cyc + 1;
        for (int i = 0; i < NTAPS; i++) drv_q.push_back('{n++, 1'b1, coef_m[NTAPS-1-i], '0});
        for (int j = 0; j < NSAMP; j++) drv_q.push_back('{n++, 1'b0, '0, samp_m[j]});
        for (int i = 0; i < NTAPS - 1 + Y_LAT + 1; i++) drv_q.push_back('{n++, 1'b0, '0, '0});
        for (int k = 0; k < NOUT; k++)
          y_q.push_back('{cyc + NTAPS + 1 + k + Y_LAT + 1, (k == NOUT - 1)});
        busy_end = cyc + PASS_LEN;
      end
    end
  end

  // Monitor: drive outputs and results are compared against the queue heads for this cycle.
  always @(negedge clk) begin
    drv_t  d;
    yexp_t e;
    if (!reset) begin
      if (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
        d = drv_q.pop_front();
        check("busy", busy, 1);
        check("x_en", x_en, d.x_en);
        check("h", h, d.h);
        check("x", x, d.x);
      end else begin
        check("busy_idle", busy, 0);
      end
      if (y_q.size() > 0 && y_q[0].cyc == cyc) begin
        e = y_q.pop_front();
        check("y_valid", y_valid, 1);
        check("y_out", y_out, yhist[(cyc - 1) % 16384]);
        check("done", done, e.done);
      end else begin
        check("y_valid_idle", y_valid, 0);
        check("done_idle", done, 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic sel, input logic [AW-1:0] addr, input logic [WL-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x_en"}, x_en, 0);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_h"}, h, 0);
    check({tag, "_y_out"}, y_out, 0);
  endtask

  // Reset is raised mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    drv_q.delete();
    y_q.delete();
    for (int i = 0; i < 8; i++) begin
      coef_m[i] = '0;
      samp_m[i] = '0;
    end
    busy_end = cyc;
    #1;
    check_zero_outputs("rst");
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [WL-1:0] c_init [3];
    logic [WL-1:0] s_init [4];
    c_init = '{8'hEB, 8'h33, 8'h1A};
    s_init = '{8'h0D, 8'hE6, 8'h26, 8'hCD};

    for (int i = 0; i < 8; i++) begin
      coef_m[i] = '0;
      samp_m[i] = '0;
    end
    tick(2);
    do_reset();

    // Pass over freshly reset tables: all zeros.
    pulse_start();
    tick(PASS_LEN + 2);

    // Reference coefficients and samples.
    for (int i = 0; i < NTAPS; i++) write(1'b0, AW'(i), c_init[i]);
    for (int j = 0; j < NSAMP; j++) write(1'b1, AW'(j), s_init[j]);
    pulse_start();
    tick(3);
    // start and table write while busy: both must be ignored.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = 8'h55; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    tick(PASS_LEN);
    pulse_start();
    tick(PASS_LEN + 2);

    // Out-of-range writes ignored; write and start in the same idle cycle.
    write(1'b0, 3'd3, 8'h77);
    write(1'b1, 3'd6, 8'h66);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd2; cfg_data = 8'h7F; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    tick(PASS_LEN + 2);

    // start held high across done: exactly two back-to-back passes.
    start = 1'b1;
    tick(PASS_LEN + 2);
    start = 1'b0;
    tick(PASS_LEN + 2);

    // Reset during STREAM abandons the pass; the next pass sees zero tables.
    pulse_start();
    tick(NTAPS + 1);
    do_reset();
    tick(PASS_LEN + 4);
    pulse_start();
    tick(PASS_LEN + 2);

    // Randomised traffic: writes and starts at arbitrary points, including while busy.
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 4; w++) write(1'($urandom), AW'($urandom), WL'($urandom));
      pulse_start();
      for (int w = 0; w < 3; w++) begin
        tick(int'($urandom_range(0, 4)));
        cfg_we = 1'($urandom); cfg_sel = 1'($urandom);
        cfg_addr = AW'($urandom); cfg_data = WL'($urandom); start = 1'($urandom);
        tick();
        cfg_we = 1'b0; start = 1'b0;
      end
      tick(int'($urandom_range(0, PASS_LEN + 2)));
    end

    tick(2 * PASS_LEN + 5);
    check("drive_queue_empty", drv_q.size(), 0);
    check("result_queue_empty", y_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
